// File: rtl/queue_ctl_pkg.sv
// rtl/queue_ctl_pkg.sv - shared constants for the queue sequencer/arbiter slice
package queue_ctl_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int DEPTH_BITS_DEF = 4;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/queue.sv
// rtl/queue.sv - show-ahead byte FIFO; one slot is sacrificed so full/empty come from pointers alone
module queue
    import queue_ctl_pkg::*;
#(
    parameter int DEPTH_BITS = DEPTH_BITS_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DATA_BITS-1:0] dat_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 oe_i,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [DEPTH_BITS-1:0] PTR_ONE = 1;

    logic [DATA_BITS-1:0]  mem [2**DEPTH_BITS];
    logic [DEPTH_BITS-1:0] wr_q, wr_d;
    logic [DEPTH_BITS-1:0] rd_q, rd_d;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = ((wr_q + PTR_ONE) == rd_q);
    assign pop_ok  = pop_i & ~empty_o;
    // A full queue still accepts a push when the same cycle frees a slot.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign dat_o   = oe_i ? mem[rd_q] : '0;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + PTR_ONE;
        if (pop_ok)  rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_q] <= dat_i;
    end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; last=1 means B won last, so A wins the next tie
module rr_arb2
    import queue_ctl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance) last_d = gnt[1];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) last_q <= 1'b1;
        else         last_q <= last_d;
    end

endmodule

// File: rtl/queue_ctl.sv
// rtl/queue_ctl.sv - merges producers A/B into one FIFO push port and drains it into a registered valid/ready stage
module queue_ctl
    import queue_ctl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int DHB       = DATA_BITS - 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [DHB:0] a_dat_i,
    input  logic         a_req_i,
    output logic         a_ack_o,
    input  logic [DHB:0] b_dat_i,
    input  logic         b_req_i,
    output logic         b_ack_o,
    input  logic         flush_i,
    output logic         busy_o,
    output logic [DHB:0] q_dat_o,
    output logic         q_push_o,
    output logic         q_pop_o,
    output logic         q_oe_o,
    input  logic [DHB:0] q_dat_i,
    input  logic         q_full_i,
    input  logic         q_empty_i,
    output logic [DHB:0] dat_o,
    output logic         valid_o,
    input  logic         ready_i
);

    logic [0:0]   state_q, state_d;
    logic         valid_q, valid_d;
    logic [DHB:0] dat_q, dat_d;
    logic         run;
    logic         pop_ok;
    logic         space;
    logic         push;
    logic [1:0]   req;
    logic [1:0]   gnt;

    assign run = (state_q == ST_RUN);

    // In FLUSH the output stage is bypassed, so drain regardless of the consumer.
    assign pop_ok  = ~q_empty_i & (run ? (~valid_q | ready_i) : 1'b1);
    assign q_pop_o = pop_ok;
    assign q_oe_o  = ~q_empty_i;

    assign space    = ~q_full_i | pop_ok;
    assign req      = run ? {b_req_i, a_req_i} : 2'b00;
    assign push     = (|gnt) & space;
    assign q_push_o = push;
    assign a_ack_o  = gnt[0] & push;
    assign b_ack_o  = gnt[1] & push;

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req     (req),
        .advance (push),
        .gnt     (gnt)
    );

    always_comb begin
        q_dat_o = '0;
        if (gnt[0])      q_dat_o = a_dat_i;
        else if (gnt[1]) q_dat_o = b_dat_i;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dat_d   = dat_q;
        if (run) begin
            if (pop_ok) begin
                dat_d   = q_dat_i;
                valid_d = 1'b1;
            end else if (ready_i & valid_q) begin
                valid_d = 1'b0;
            end
            if (flush_i) begin
                state_d = ST_FLUSH;
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
            if (q_empty_i) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dat_q   <= dat_d;
        end
    end

    assign busy_o  = ~run;
    assign valid_o = valid_q;
    assign dat_o   = dat_q;

endmodule

// File: tb/tb_queue_ctl.sv
// tb/tb_queue_ctl.sv - directed scoreboard bench for queue_ctl driving a real queue
module tb_queue_ctl;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] a_dat_i = '0, b_dat_i = '0;
    logic       a_req_i = 1'b0, b_req_i = 1'b0;
    logic       a_ack_o, b_ack_o;
    logic       flush_i = 1'b0;
    logic       busy_o;
    logic [7:0] q_dat_w, q_rd_w;
    logic       q_push_w, q_pop_w, q_oe_w, q_full_w, q_empty_w;
    logic [7:0] dat_o;
    logic       valid_o;
    logic       ready_i = 1'b0;

    always #5 clk = ~clk;

    queue_ctl dut (
        .clk_i(clk), .reset_i(reset_i),
        .a_dat_i(a_dat_i), .a_req_i(a_req_i), .a_ack_o(a_ack_o),
        .b_dat_i(b_dat_i), .b_req_i(b_req_i), .b_ack_o(b_ack_o),
        .flush_i(flush_i), .busy_o(busy_o),
        .q_dat_o(q_dat_w), .q_push_o(q_push_w), .q_pop_o(q_pop_w), .q_oe_o(q_oe_w),
        .q_dat_i(q_rd_w), .q_full_i(q_full_w), .q_empty_i(q_empty_w),
        .dat_o(dat_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    queue u_queue (
        .clk_i(clk), .reset_i(reset_i),
        .dat_i(q_dat_w), .push_i(q_push_w), .pop_i(q_pop_w), .oe_i(q_oe_w),
        .dat_o(q_rd_w), .full_o(q_full_w), .empty_o(q_empty_w)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] a_q[$], b_q[$], sb[$], out_log[$];
    logic [3:0] ack_bits;
    int         ack_cnt, b_ack_cnt, n_acks;
    logic       s_aack, s_back, s_valid, s_busy, s_pop, s_push, s_full;
    logic [7:0] s_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive producers from their pending queues, sample mid-cycle, then advance.
    task automatic cycle();
        logic [7:0] e;
        a_req_i = (a_q.size() > 0);
        a_dat_i = a_req_i ? a_q[0] : 8'h00;
        b_req_i = (b_q.size() > 0);
        b_dat_i = b_req_i ? b_q[0] : 8'h00;
        #2;
        s_aack = a_ack_o; s_back = b_ack_o; s_valid = valid_o; s_dat = dat_o;
        s_busy = busy_o; s_pop = q_pop_w; s_push = q_push_w; s_full = q_full_w;
        chk("invariant", {29'd0, q_pop_w & q_empty_w, q_push_w & q_full_w & ~q_pop_w,
                          a_ack_o & b_ack_o}, 32'd0);
        if (a_ack_o) begin
            sb.push_back(a_dat_i); void'(a_q.pop_front());
            ack_cnt++; n_acks++; ack_bits = {ack_bits[2:0], 1'b0};
        end
        if (b_ack_o) begin
            sb.push_back(b_dat_i); void'(b_q.pop_front());
            ack_cnt++; b_ack_cnt++; n_acks++; ack_bits = {ack_bits[2:0], 1'b1};
        end
        if (valid_o && ready_i) begin
            out_log.push_back(dat_o);
            if (sb.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("out_data", {24'd0, dat_o}, {24'd0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        a_q.delete(); b_q.delete(); sb.delete(); out_log.delete();
        a_req_i = 1'b0; b_req_i = 1'b0; a_dat_i = '0; b_dat_i = '0;
        flush_i = 1'b0; ready_i = 1'b0;
        ack_cnt = 0; b_ack_cnt = 0; n_acks = 0; ack_bits = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_i = 1'b1;
        while ((a_q.size() > 0 || b_q.size() > 0 || sb.size() > 0) && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_timeout", {31'd0, n >= 100}, 32'd0);
    endtask

    initial begin
        int n, busy_cnt, bad, both;

        // Reset state
        do_reset();
        #1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_dat", {24'd0, dat_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_comb", {27'd0, a_ack_o, b_ack_o, q_push_w, q_pop_w, q_oe_w}, 32'd0);
        chk("rst_qdat", {24'd0, q_dat_w}, 32'd0);
        @(negedge clk);

        // Single push latency
        do_reset();
        ready_i = 1'b1;
        a_q.push_back(8'h41);
        cycle();
        chk("t1_a_ack", {31'd0, s_aack}, 32'd1);
        chk("t1_b_ack", {31'd0, s_back}, 32'd0);
        cycle();
        chk("t1_pop_n1", {31'd0, s_pop}, 32'd1);
        chk("t1_valid_n1", {31'd0, s_valid}, 32'd0);
        cycle();
        chk("t1_valid_n2", {31'd0, s_valid}, 32'd1);
        chk("t1_dat_n2", {24'd0, s_dat}, 32'h41);
        repeat (3) cycle();
        chk("t1_b_never", b_ack_cnt, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Round-robin fairness
        do_reset();
        ready_i = 1'b1;
        a_q.push_back(8'h10); a_q.push_back(8'h11);
        b_q.push_back(8'h20); b_q.push_back(8'h21);
        repeat (8) cycle();
        chk("t2_n_acks", n_acks, 4);
        chk("t2_ack_order", {28'd0, ack_bits}, 32'h5);
        chk("t2_out_cnt", out_log.size(), 4);
        if (out_log.size() == 4)
            chk("t2_out_seq", {out_log[0], out_log[1], out_log[2], out_log[3]}, 32'h10201121);

        // Back-pressure: 17 bytes against a stalled consumer
        do_reset();
        for (int i = 0; i < 17; i++) a_q.push_back(8'h80 + 8'(i));
        repeat (24) cycle();
        chk("t3_acks_stalled", ack_cnt, 16);
        chk("t3_held_req", {31'd0, a_req_i}, 32'd1);
        chk("t3_valid", {31'd0, s_valid}, 32'd1);
        chk("t3_dat_first", {24'd0, s_dat}, 32'h80);
        drain();
        chk("t3_acks_total", ack_cnt, 17);
        chk("t3_out_cnt", out_log.size(), 17);
        if (out_log.size() == 17) chk("t3_out_last", {24'd0, out_log[16]}, 32'h90);

        // Flush, with a push in the flush cycle and a request pending during FLUSH
        do_reset();
        for (int i = 0; i < 5; i++) a_q.push_back(8'h50 + 8'(i));
        repeat (8) cycle();
        chk("t4_fill", ack_cnt, 5);
        a_q.push_back(8'h99);
        flush_i = 1'b1;
        cycle();
        chk("t4_push_on_flush", {31'd0, s_aack}, 32'd1);
        sb.delete();
        a_q.push_back(8'h9a);
        busy_cnt = 0; bad = 0; n = 0;
        cycle();
        while (s_busy && n < 20) begin
            busy_cnt++;
            if (s_aack || s_valid) bad++;
            cycle();
            n++;
        end
        chk("t4_busy_cycles", busy_cnt, 6);
        chk("t4_no_ack_valid_busy", bad, 0);
        chk("t4_ack_after_busy", {31'd0, s_aack}, 32'd1);
        chk("t4_valid_after", {31'd0, s_valid}, 32'd0);
        out_log.delete();
        drain();
        chk("t4_out_cnt", out_log.size(), 1);
        if (out_log.size() == 1) chk("t4_out_byte", {24'd0, out_log[0]}, 32'h9a);

        // Full queue: push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 24; i++) a_q.push_back(8'hc0 + 8'(i));
        n = 0;
        while (ack_cnt < 16 && n < 40) begin
            cycle();
            n++;
        end
        chk("t5_fill_timeout", {31'd0, n >= 40}, 32'd0);
        chk("t5_full", {31'd0, q_full_w}, 32'd1);
        ready_i = 1'b1;
        both = 0;
        repeat (8) begin
            cycle();
            if (s_push && s_pop && s_full) both++;
        end
        chk("t5_push_pop_full", both, 8);
        drain();
        chk("t5_out_cnt", out_log.size(), 24);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) a_q.push_back(8'h30 + 8'(i));
        repeat (5) cycle();
        chk("t6_valid_before", {31'd0, s_valid}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_valid_async", {31'd0, valid_o}, 32'd0);
        do_reset();
        for (int i = 0; i < 3; i++) a_q.push_back(8'h60 + 8'(i));
        repeat (5) cycle();
        flush_i = 1'b1;
        cycle();
        cycle();
        chk("t6_busy_before", {31'd0, s_busy}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_busy_async", {31'd0, busy_o}, 32'd0);
        do_reset();
        chk("t6_queue_cleared", {31'd0, q_empty_w}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
